// File: rtl/muldiv_unit.sv
// muldiv_unit
// Multi-cycle HI/LO engine for MULT, MULTU, DIV and DIVU. It sits in EX beside
// the ALU and owns the HI and LO registers used by MFHI/MFLO/MTHI/MTLO.
// Multiplies use a radix-2 shift-add over operand magnitudes. Divides use a
// restoring shift-subtract over operand magnitudes. A final FIX cycle applies
// the result signs and commits HI/LO.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   start, op      request an operation (sampled only in IDLE), OP_* select
//   src_a, src_b   multiplicand/dividend and multiplier/divisor
//   flush          cancel an in-flight operation without committing
//   hi_we, lo_we   MTHI / MTLO write enables, data on wdata
//   hi, lo         HI and LO registers
//   busy           high whenever the engine is not IDLE
//   done           one-cycle pulse in the cycle after a result is committed
module muldiv_unit #(
   parameter int         WIDTH     = 32,
   parameter logic [1:0] OP_MULT   = 2'b00,
   parameter logic [1:0] OP_MULTU  = 2'b01,
   parameter logic [1:0] OP_DIV    = 2'b10,
   parameter logic [1:0] OP_DIVU   = 2'b11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             flush,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      counter_q, counter_d;
   logic               is_div_q, is_div_d;
   logic               neg_q, neg_d;
   logic               rem_neg_q, rem_neg_d;
   logic [WIDTH-1:0]   mag_q, mag_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;

   // Operand decode used only when a request is accepted in IDLE.
   logic               op_signed;
   logic               op_div;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;

   assign op_signed = (op == OP_MULT) || (op == OP_DIV);
   assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
   assign abs_a     = (op_signed && src_a[WIDTH-1]) ? -src_a : src_a;
   assign abs_b     = (op_signed && src_b[WIDTH-1]) ? -src_b : src_b;

   // Multiply step: acc holds {partial product, remaining multiplier bits}.
   // The carry out of the add is shifted back into the top of acc.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;

   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, mag_q} : {(WIDTH+1){1'b0}});
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

   // Divide step: acc holds {remainder, dividend bits / quotient bits}.
   // The shifted remainder needs one extra bit before the trial subtract.
   // When it fits, the true difference is below 2^WIDTH, so a WIDTH-bit
   // subtract is exact.
   logic [WIDTH:0]     div_rem_sh;
   logic               div_fits;
   logic [WIDTH-1:0]   div_diff;
   logic [2*WIDTH-1:0] div_next;

   assign div_rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
   assign div_fits   = div_rem_sh >= {1'b0, mag_q};
   assign div_diff   = div_rem_sh[WIDTH-1:0] - mag_q;
   assign div_next   = div_fits ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                                : {div_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

   // Sign fix applied in FIX. The remainder follows the dividend sign, which
   // gives truncation toward zero.
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix;
   logic [WIDTH-1:0]   rem_fix;

   assign prod_fix = neg_q ? -acc_q : acc_q;
   assign quot_fix = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

   // Next-state and datapath logic.
   // MTHI/MTLO writes go in first, so a FIX commit on the same edge overrides
   // them. Flush takes priority over everything else the engine would do,
   // including a commit or a start on the same edge.
   always_comb begin
      state_d   = state_q;
      counter_d = counter_q;
      is_div_d  = is_div_q;
      neg_d     = neg_q;
      rem_neg_d = rem_neg_q;
      mag_d     = mag_q;
      acc_d     = acc_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;

      if (hi_we) hi_d = wdata;
      if (lo_we) lo_d = wdata;

      if (flush) begin
         if (state_q != IDLE) state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  is_div_d  = op_div;
                  counter_d = '0;
                  neg_d     = op_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                  rem_neg_d = (op == OP_DIV) && src_a[WIDTH-1];
                  if (op_div && (src_b == '0)) begin
                     // Divide by zero: FIX commits acc unchanged.
                     // This gives hi = src_a and lo = all ones.
                     acc_d     = {src_a, {WIDTH{1'b1}}};
                     neg_d     = 1'b0;
                     rem_neg_d = 1'b0;
                     state_d   = FIX;
                  end else if (op_div) begin
                     mag_d   = abs_b;
                     acc_d   = {{WIDTH{1'b0}}, abs_a};
                     state_d = CALC;
                  end else begin
                     mag_d   = abs_a;
                     acc_d   = {{WIDTH{1'b0}}, abs_b};
                     state_d = CALC;
                  end
               end
            end
            CALC: begin
               counter_d = counter_q + 1'b1;
               acc_d     = is_div_q ? div_next : mul_next;
               if (counter_q == CW'(WIDTH-1)) state_d = FIX;
            end
            FIX: begin
               if (is_div_q) begin
                  hi_d = rem_fix;
                  lo_d = quot_fix;
               end else begin
                  hi_d = prod_fix[2*WIDTH-1:WIDTH];
                  lo_d = prod_fix[WIDTH-1:0];
               end
               done_d  = 1'b1;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State and datapath registers.
   // Reset discards any in-flight work immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         counter_q <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         mag_q     <= '0;
         acc_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         counter_q <= counter_d;
         is_div_q  <= is_div_d;
         neg_q     <= neg_d;
         rem_neg_q <= rem_neg_d;
         mag_q     <= mag_d;
         acc_q     <= acc_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
      end
   end

   assign hi   = hi_q;
   assign lo   = lo_q;
   assign busy = (state_q != IDLE);
   assign done = done_q;

endmodule
